ws2812_frame_driver: RTL
========================

// Module: ws2812_frame_driver
// PURPOSE
//  Streams a frame of NUM_PIXELS colour words to a WS2812B-style LED chain on one wire.
//  Pixels arrive on a valid/ready handshake into a one-entry holding register, so bits are back-to-back.
//  Each bit is encoded MSB-first as a timed high/low pulse; the frame ends with a reset/latch gap.
//  Sits between the cube-face pixel generator and the LED matrix pin; replaces the fixed 24-bit, one-pixel-per-reset stream.
// PARAMETERS
//  NUM_PIXELS     64    pixels per frame (>=1)
//  BITS_PER_PIXEL 24    bits per pixel word, multiple of 8 (24 = GRB, 32 = GRBW)
//  T0H_CYC        16    clk cycles high for a 0 bit (0.40 us at 40 MHz)
//  T1H_CYC        32    clk cycles high for a 1 bit (0.80 us)
//  T0L_CYC        34    clk cycles low for a 0 bit (0.85 us)
//  T1L_CYC        18    clk cycles low for a 1 bit (0.45 us)
//  RES_CYC        2000  clk cycles low for the latch gap (50 us)
// PORTS
//  clk         in   1               system clock
//  reset       in   1               synchronous, active-high reset
//  start       in   1               pulse; begins a frame when idle
//  pix_data    in   BITS_PER_PIXEL  pixel word; MSB is transmitted first
//  pix_valid   in   1               pix_data is valid
//  pix_ready   out  1               driver accepts pix_data this cycle
//  brightness  in   8               global scale; used only with WS2812_BRIGHTNESS_EN
//  busy        out  1               high from start acceptance until frame_done
//  frame_done  out  1               one-cycle pulse when the latch gap completes
//  underrun    out  1               one-cycle pulse when a stall begins mid-frame
//  dout        out  1               serial LED data line
// BEHAVIOUR
//  Reset: all outputs are 0 on the cycle after reset is sampled. State = IDLE; hold register is empty; counters = 0.
//    Reset mid-frame aborts the frame with no frame_done.
//  Transfer: a pixel is accepted when pix_valid & pix_ready. pix_ready = busy & ~hold_full & (accepted < NUM_PIXELS).
//  States:
//   IDLE: start=1 -> FETCH and busy=1. start is ignored in every other state.
//   FETCH: waits, with dout=0, for the first pixel to be present in hold. Moves hold into the shift register -> HIGH.
//     No underrun is raised in FETCH.
//   HIGH: dout=1 for T0H_CYC or T1H_CYC cycles, chosen by the current bit -> LOW.
//   LOW: dout=0 for T0L_CYC or T1L_CYC cycles. On expiry:
//     - More bits remain in the word: shift, -> HIGH.
//     - Last bit, more pixels due, hold full: load shift register from hold in the same cycle, -> HIGH. No gap cycle.
//     - Last bit, more pixels due, hold empty: -> STALL with a one-cycle underrun pulse.
//     - Last bit of pixel NUM_PIXELS: -> LATCH.
//   STALL: dout=0. Exits to HIGH the cycle after hold becomes full, loading the shift register on that cycle.
//     A stall longer than RES_CYC latches the chain early; avoiding this is the producer's responsibility.
//   LATCH: dout=0 for RES_CYC cycles. Final cycle -> IDLE with frame_done=1 and busy=0 on the next cycle.
//     A start asserted in the frame_done cycle is ignored.
//  Cycle count: every bit occupies exactly 50 cycles at the defaults. A frame with no stalls takes
//    NUM_PIXELS*BITS_PER_PIXEL*(bit cycles) + RES_CYC cycles from the first HIGH to frame_done.
//  Counter widths: $clog2 of (max duration + 1), $clog2(NUM_PIXELS+1) and $clog2(BITS_PER_PIXEL).
//    No wrap-around is permitted.
//  Simultaneous events: a hold load and a hold drain in the same cycle leave hold full with the new word.
// CONFIGURATION
//  WS2812_BRIGHTNESS_EN defined: each 8-bit channel c is stored as (c*(brightness+1))>>8 at accept time.
//    brightness is sampled at the handshake. brightness=255 leaves the data unchanged.
//  Not defined: brightness is ignored and no multiplier logic exists. pix_data is stored unchanged.
// STRUCTURE
//  ws2812_pkg: state enum (IDLE, FETCH, HIGH, LOW, STALL, LATCH) and default timing constants for 40 MHz.
//  Sub-module ws2812_bit_timer: loadable down-counter with a one-cycle expire pulse.
//    Duration is selected by state and bit. One instance is used for all pulse and latch timing.
// TESTING  (bench params unless noted: NUM_PIXELS=2, T0H=2, T1H=4, T0L=4, T1L=2, RES=10)
//  1. Assert reset for 2 cycles mid-stream -> next cycle: dout=0, busy=0, pix_ready=0, frame_done=0, underrun=0.
//  2. start, then 24'h800001 and 24'h000000 offered immediately:
//     -> bit 23 high 4 / low 2, bits 22..1 high 2 / low 4, bit 0 high 4 / low 2.
//     -> All pixel-2 bits are 0-bits; the frame has no gaps.
//     -> frame_done fires exactly 10 cycles after the last LOW ends.
//  3. Second pixel withheld 20 cycles past pixel-1 end -> underrun pulses once, dout=0 for 20 cycles,
//     then pixel-2 streams correctly and frame_done follows.
//  4. start pulsed during HIGH and again in the frame_done cycle -> both ignored; busy stays low afterwards.
//  5. With WS2812_BRIGHTNESS_EN, pixel 24'hFF8040 at brightness=127 -> 24'h7F4020 sent.
//     Without the macro -> 24'hFF8040 sent.
//  6. Defaults, 64 pixels always valid -> 76800 + 2000 cycles from the first HIGH to frame_done, with no underrun.

Source files
------------

// File: rtl/ws2812_pkg.sv
// Shared state encoding and default 40 MHz timing for the WS2812 frame driver.
package ws2812_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    HIGH,
    LOW,
    STALL,
    LATCH
  } state_t;

  localparam int DEF_NUM_PIXELS     = 64;
  localparam int DEF_BITS_PER_PIXEL = 24;
  localparam int DEF_T0H_CYC        = 16;
  localparam int DEF_T1H_CYC        = 32;
  localparam int DEF_T0L_CYC        = 34;
  localparam int DEF_T1L_CYC        = 18;
  localparam int DEF_RES_CYC        = 2000;

  function automatic int ws_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ws2812_bit_timer.sv
// Loadable down-counter; expire pulses on the last cycle of a loaded duration.
module ws2812_bit_timer #(
  parameter int W = 11
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         armed_q, armed_d;

  // load_val is duration-1, so a load of 0 expires on the very next cycle.
  always_comb begin
    expire  = armed_q && (cnt_q == '0);
    cnt_d   = cnt_q;
    armed_d = armed_q & ~expire;
    if (load) begin
      cnt_d   = load_val;
      armed_d = 1'b1;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      armed_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      armed_q <= armed_d;
    end
  end

endmodule

// File: rtl/ws2812_frame_driver.sv
// Streams NUM_PIXELS words MSB-first as WS2812 pulses, then a latch gap.
// Optional global brightness scaling at accept time: define WS2812_BRIGHTNESS_EN.
module ws2812_frame_driver
  import ws2812_pkg::*;
#(
  parameter int NUM_PIXELS     = DEF_NUM_PIXELS,
  parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
  parameter int T0H_CYC        = DEF_T0H_CYC,
  parameter int T1H_CYC        = DEF_T1H_CYC,
  parameter int T0L_CYC        = DEF_T0L_CYC,
  parameter int T1L_CYC        = DEF_T1L_CYC,
  parameter int RES_CYC        = DEF_RES_CYC
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [BITS_PER_PIXEL-1:0] pix_data,
  input  logic                      pix_valid,
  output logic                      pix_ready,
  input  logic [7:0]                brightness,
  output logic                      busy,
  output logic                      frame_done,
  output logic                      underrun,
  output logic                      dout
);

  localparam int MAX_DUR = ws_max(ws_max(T0H_CYC, T1H_CYC),
                                  ws_max(ws_max(T0L_CYC, T1L_CYC), RES_CYC));
  localparam int TW  = $clog2(MAX_DUR + 1);
  localparam int PW  = $clog2(NUM_PIXELS + 1);
  localparam int BW  = $clog2(BITS_PER_PIXEL);
  localparam int MSB = BITS_PER_PIXEL - 1;

  state_t                  state_q, state_d;
  logic [BITS_PER_PIXEL-1:0] shift_q, shift_d, hold_q, hold_d, pix_stored;
  logic                    hold_full_q, hold_full_d;
  logic [BW-1:0]           bit_q, bit_d;
  logic [PW-1:0]           acc_q, acc_d, sent_q, sent_d;
  logic                    frame_done_q, frame_done_d, underrun_q, underrun_d;
  logic                    accept, drain, load_word;
  logic                    tmr_load, tmr_expire;
  logic [TW-1:0]           tmr_val;

`ifdef WS2812_BRIGHTNESS_EN
  for (genvar gi = 0; gi < BITS_PER_PIXEL / 8; gi++) begin : g_scale
    logic [15:0] prod;
    assign prod = {8'd0, pix_data[gi*8 +: 8]} * ({8'd0, brightness} + 16'd1);
    assign pix_stored[gi*8 +: 8] = prod[15:8];
  end
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign pix_stored        = pix_data;
`endif

  function automatic logic [TW-1:0] high_len(input logic b);
    return b ? TW'(T1H_CYC - 1) : TW'(T0H_CYC - 1);
  endfunction

  function automatic logic [TW-1:0] low_len(input logic b);
    return b ? TW'(T1L_CYC - 1) : TW'(T0L_CYC - 1);
  endfunction

  assign busy       = (state_q != IDLE);
  assign dout       = (state_q == HIGH);
  assign frame_done = frame_done_q;
  assign underrun   = underrun_q;
  assign pix_ready  = busy & ~hold_full_q & (acc_q < PW'(NUM_PIXELS));
  assign accept     = pix_valid & pix_ready;

  always_comb begin
    state_d      = state_q;
    shift_d      = shift_q;
    bit_d        = bit_q;
    sent_d       = sent_q;
    frame_done_d = 1'b0;
    underrun_d   = 1'b0;
    drain        = 1'b0;
    load_word    = 1'b0;
    tmr_load     = 1'b0;
    tmr_val      = '0;

    unique case (state_q)
      IDLE: begin
        bit_d  = '0;
        sent_d = '0;
        // The frame_done cycle is still IDLE; a start there must not re-arm.
        if (start && !frame_done_q) state_d = FETCH;
      end
      FETCH: begin
        if (hold_full_q) load_word = 1'b1;
      end
      HIGH: begin
        if (tmr_expire) begin
          state_d  = LOW;
          tmr_load = 1'b1;
          tmr_val  = low_len(shift_q[MSB]);
        end
      end
      LOW: begin
        if (tmr_expire) begin
          if (bit_q != BW'(MSB)) begin
            shift_d  = shift_q << 1;
            bit_d    = bit_q + 1'b1;
            state_d  = HIGH;
            tmr_load = 1'b1;
            tmr_val  = high_len(shift_q[MSB-1]);
          end else if (sent_q == PW'(NUM_PIXELS)) begin
            state_d  = LATCH;
            tmr_load = 1'b1;
            tmr_val  = TW'(RES_CYC - 1);
          end else if (hold_full_q) begin
            load_word = 1'b1;
          end else begin
            state_d    = STALL;
            underrun_d = 1'b1;
          end
        end
      end
      STALL: begin
        if (hold_full_q) load_word = 1'b1;
      end
      LATCH: begin
        if (tmr_expire) begin
          state_d      = IDLE;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load_word) begin
      shift_d  = hold_q;
      bit_d    = '0;
      sent_d   = sent_q + 1'b1;
      drain    = 1'b1;
      state_d  = HIGH;
      tmr_load = 1'b1;
      tmr_val  = high_len(hold_q[MSB]);
    end

    // A fresh accept wins over a drain in the same cycle.
    hold_full_d = accept | (hold_full_q & ~drain);
    hold_d      = accept ? pix_stored : hold_q;
    acc_d       = (state_q == IDLE) ? '0 : acc_q + PW'(accept);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      bit_q        <= '0;
      acc_q        <= '0;
      sent_q       <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      bit_q        <= bit_d;
      acc_q        <= acc_d;
      sent_q       <= sent_d;
      frame_done_q <= frame_done_d;
      underrun_q   <= underrun_d;
    end
  end

  ws2812_bit_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expire   (tmr_expire)
  );

endmodule
